// File: rtl/mmul_param.sv
// mmul_param -- parametrised serial-load modular multiplier / adder.
//
// Operands a, b and modulus p are loaded W bits per clock, least significant
// word first. After a start request the block computes either a*b mod p
// (bit-serial interleaved double/add/reduce, one bit of b per clock, MSB
// first) or (a+b) mod p (single cycle). The N-bit result R is read back W bits
// per clock.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous reset, active low
//   datain     load word (W bits)
//   loada      write datain into a at the a pointer (priority a > b > p)
//   loadb      write datain into b at the b pointer
//   loadp      write datain into p at the p pointer
//   mode       sampled at start: 0 = a*b mod p, 1 = (a+b) mod p
//   mmul_en    start request, single-cycle pulse
//   outr       read the result word at the read pointer
//   dout       registered result word
//   dout_vld   dout valid, one cycle after each outr cycle
//   mmul_busy  high while checking operands / calculating
//   mmul_rdy   high from completion until the next accepted start
//   c_flag     00 ok, 01 a>=p or b>=p, 10 p==0
module mmul_param #(
  parameter int N = 256,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] datain,
  input  logic         loada,
  input  logic         loadb,
  input  logic         loadp,
  input  logic         mode,
  input  logic         mmul_en,
  input  logic         outr,
  output logic [W-1:0] dout,
  output logic         dout_vld,
  output logic         mmul_busy,
  output logic         mmul_rdy,
  output logic [1:0]   c_flag
);

  localparam int NW = N / W;
  localparam int PW = (NW > 1) ? $clog2(NW) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_CALC,
    S_DONE
  } state_t;

  state_t state, state_nx;

  // Operands and result are held as word arrays so loads and readout index
  // words directly; the packed form still behaves as one N-bit number.
  logic [NW-1:0][W-1:0] a_q, b_q, p_q, r_q, r_nx;
  logic [N-1:0]         b_flat;

  logic [PW-1:0] ptr_a, ptr_b, ptr_p, rptr;
  logic [IW-1:0] bit_idx, bit_idx_nx;
  logic          mode_q;
  logic [1:0]    flag_nx;
  logic          busy_nx, rdy_nx;
  logic          idle_like, any_load, accept;

  // N+1 bit intermediates of the reduction steps
  logic [N:0] p_ext, t_dbl, t_red, t_add, t_mul, t_sum, t_mod;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] x);
    return (x == PW'(NW - 1)) ? '0 : x + 1'b1;
  endfunction

  assign b_flat    = b_q;
  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign any_load  = loada | loadb | loadp;
  assign accept    = idle_like & mmul_en & ~any_load;

  // ---------------------------------------------------------------------
  // Arithmetic for one CALC step. R < p always holds, so 2R < 2p and
  // R' + a < 2p: a single conditional subtract after each add suffices.
  // ---------------------------------------------------------------------
  always_comb begin
    p_ext = {1'b0, p_q};
    t_dbl = {r_q, 1'b0};
    t_red = (t_dbl >= p_ext) ? (t_dbl - p_ext) : t_dbl;
    t_add = b_flat[bit_idx] ? (t_red + {1'b0, a_q}) : t_red;
    t_mul = (t_add >= p_ext) ? (t_add - p_ext) : t_add;
    t_sum = {1'b0, a_q} + {1'b0, b_q};
    t_mod = (t_sum >= p_ext) ? (t_sum - p_ext) : t_sum;
  end

  // ---------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    r_nx       = r_q;
    flag_nx    = c_flag;
    bit_idx_nx = bit_idx;
    busy_nx    = mmul_busy;
    rdy_nx     = mmul_rdy;

    unique case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_nx = S_CHECK;
          busy_nx  = 1'b1;
          rdy_nx   = 1'b0;
        end
      end

      S_CHECK: begin
        r_nx       = '0;
        bit_idx_nx = IW'(N - 1);
        if (p_q == '0) begin
          flag_nx  = 2'b10;
          state_nx = S_DONE;
          busy_nx  = 1'b0;
          rdy_nx   = 1'b1;
        end else if ((a_q >= p_q) || (b_q >= p_q)) begin
          flag_nx  = 2'b01;
          state_nx = S_DONE;
          busy_nx  = 1'b0;
          rdy_nx   = 1'b1;
        end else begin
          flag_nx  = 2'b00;
          state_nx = S_CALC;
        end
      end

      S_CALC: begin
        if (mode_q) begin
          r_nx     = t_mod[N-1:0];
          state_nx = S_DONE;
          busy_nx  = 1'b0;
          rdy_nx   = 1'b1;
        end else begin
          r_nx = t_mul[N-1:0];
          if (bit_idx == '0) begin
            state_nx = S_DONE;
            busy_nx  = 1'b0;
            rdy_nx   = 1'b1;
          end else begin
            bit_idx_nx = bit_idx - 1'b1;
          end
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q       <= '0;
      c_flag    <= '0;
      bit_idx   <= '0;
      mode_q    <= 1'b0;
      mmul_busy <= 1'b0;
      mmul_rdy  <= 1'b0;
    end else begin
      r_q       <= r_nx;
      c_flag    <= flag_nx;
      bit_idx   <= bit_idx_nx;
      mmul_busy <= busy_nx;
      mmul_rdy  <= rdy_nx;
      if (accept) begin
        mode_q <= mode;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Operand loading. A pointer clears whenever its own load is low; a load
  // that loses priority, or arrives while busy, leaves its pointer as is.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      ptr_a <= '0;
      ptr_b <= '0;
      ptr_p <= '0;
    end else begin
      if (loada) begin
        if (idle_like) begin
          a_q[ptr_a] <= datain;
          ptr_a      <= inc_ptr(ptr_a);
        end
      end else begin
        ptr_a <= '0;
      end

      if (loadb) begin
        if (idle_like && !loada) begin
          b_q[ptr_b] <= datain;
          ptr_b      <= inc_ptr(ptr_b);
        end
      end else begin
        ptr_b <= '0;
      end

      if (loadp) begin
        if (idle_like && !loada && !loadb) begin
          p_q[ptr_p] <= datain;
          ptr_p      <= inc_ptr(ptr_p);
        end
      end else begin
        ptr_p <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Result readout; independent of the FSM, so a read while busy returns
  // whatever R currently holds.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      rptr     <= '0;
    end else if (outr) begin
      dout     <= r_q[rptr];
      dout_vld <= 1'b1;
      rptr     <= inc_ptr(rptr);
    end else begin
      dout_vld <= 1'b0;
      rptr     <= '0;
    end
  end

endmodule
